// File: rtl/div_requester.sv
`default_nettype none
// ============================================================================
// Module   : div_requester
// Purpose  : Initiator for the sequential divider. Takes operand pairs over
//            valid/ready, fires a one-cycle start, waits for a completion
//            pulse (or a timeout) and returns quotient plus status downstream.
// Revision : 1.0  initial release
// ============================================================================
module div_requester #(
  parameter int WIDTH   = 10,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_busy,
  input  logic             div_valid,
  input  logic             div_dvz,
  input  logic             div_ovf,
  input  logic [WIDTH-1:0] div_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       out_status,
  output logic [7:0]       err_count
);

  // Timer only has to count up to TIMEOUT-1 before WAIT is abandoned.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_DVZ = 2'b01;
  localparam logic [1:0] ST_OVF = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t         r_state;
  logic [TW-1:0]  r_timer;
  logic [7:0]     w_err_next;
  logic           w_timer_last;
  logic           w_unused;

  // Busy is advisory only; completion is judged purely on the pulses.
  assign w_unused = div_busy;

  assign w_err_next   = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
  assign w_timer_last = (r_timer == TW'(TIMEOUT - 1));

  // Handshake flags are straight decodes of the state register.
  assign in_ready  = (r_state == S_IDLE);
  assign div_start = (r_state == S_ISSUE);
  assign out_valid = (r_state == S_HOLD);

  // Request sequencer: accept, issue, wait for completion/timeout, present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      div_a      <= '0;
      div_b      <= '0;
      out_q      <= '0;
      out_status <= ST_OK;
      err_count  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            div_a   <= in_a;
            div_b   <= in_b;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          // A pulse in the final timer cycle still beats the timeout.
          if (div_dvz) begin
            out_q      <= '0;
            out_status <= ST_DVZ;
            err_count  <= w_err_next;
            r_state    <= S_HOLD;
          end else if (div_ovf) begin
            out_q      <= '0;
            out_status <= ST_OVF;
            err_count  <= w_err_next;
            r_state    <= S_HOLD;
          end else if (div_valid) begin
            out_q      <= div_q;
            out_status <= ST_OK;
            r_state    <= S_HOLD;
          end else if (w_timer_last) begin
            out_q      <= '0;
            out_status <= ST_TMO;
            err_count  <= w_err_next;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_requester
// Purpose  : Directed plus randomized bench for div_requester with a
//            behavioural divider/result model.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_requester;

  localparam int WIDTH   = 10;
  localparam int TIMEOUT = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             div_start;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_busy = 1'b0;
  logic             div_valid = 1'b0;
  logic             div_dvz = 1'b0;
  logic             div_ovf = 1'b0;
  logic [WIDTH-1:0] div_q = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_q;
  logic [1:0]       out_status;
  logic [7:0]       err_count;

  int n_vec   = 0;
  int n_err   = 0;
  int n_start = 0;
  int s_start = 0;
  int exp_err = 0;
  logic [WIDTH-1:0] exp_q;
  logic [1:0]       exp_st;

  div_requester #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_valid(div_valid), .div_dvz(div_dvz),
    .div_ovf(div_ovf), .div_q(div_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
    .out_status(out_status), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Count every start pulse the DUT issues.
  always @(posedge clk) if (div_start === 1'b1) n_start++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // What an ideal divider returns for a pair.
  function automatic logic [WIDTH-1:0] divq(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (b == 0) ? '1 : WIDTH'(int'(a) / int'(b));
  endfunction

  // Result model: first pulse inside the timeout window wins by priority,
  // otherwise the request times out. Errors saturate at 255.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit dvz, input bit ovf, input bit vld, input int d);
    if ((dvz || ovf || vld) && d < TIMEOUT) begin
      if (dvz)      begin exp_st = 2'd1; exp_q = '0; end
      else if (ovf) begin exp_st = 2'd2; exp_q = '0; end
      else          begin exp_st = 2'd0; exp_q = divq(a, b); end
    end else begin
      exp_st = 2'd3; exp_q = '0;
    end
    if (exp_st != 2'd0 && exp_err < 255) exp_err++;
  endtask

  // Accept in IDLE, then the start pulse and entry into WAIT.
  task automatic issue_check(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    check("start_hi", div_start, 1);
    check("div_a_latch", div_a, a);
    check("div_b_latch", div_b, b);
    step();
    check("start_lo", div_start, 0);
    check("start_count", n_start, s_start + 1);
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    check("in_ready_idle", in_ready, 1);
    s_start  = n_start;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    issue_check(a, b);
  endtask

  // Called right after WAIT entry; drives the divider response after d cycles.
  task automatic complete(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit dvz, input bit ovf, input bit vld, input int d);
    model(a, b, dvz, ovf, vld, d);
    if ((dvz || ovf || vld) && d < TIMEOUT) begin
      repeat (d) step();
      check("no_early_valid", out_valid, 0);
      div_dvz   = dvz;
      div_ovf   = ovf;
      div_valid = vld;
      div_q     = divq(a, b);
      step();
      div_dvz = 1'b0; div_ovf = 1'b0; div_valid = 1'b0;
    end else begin
      repeat (TIMEOUT - 1) step();
      check("pre_timeout", out_valid, 0);
      step();
    end
    check("out_valid", out_valid, 1);
    check("out_q", out_q, exp_q);
    check("out_status", out_status, exp_st);
    check("err_count", err_count, exp_err);
    check("in_ready_hold", in_ready, 0);
    check("div_a_stable", div_a, a);
    check("div_b_stable", div_b, b);
  endtask

  task automatic release_out(input int hold);
    repeat (hold) begin
      step();
      check("bp_valid", out_valid, 1);
      check("bp_q", out_q, exp_q);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("released", out_valid, 0);
    check("ready_after", in_ready, 1);
    check("single_start", n_start, s_start + 1);
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    bit dvz, ovf, vld;
    int d;

    // Reset state
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_start", div_start, 0);
    check("rst_err", err_count, 0);
    check("rst_status", out_status, 0);
    step();
    rst_n = 1'b1;
    step();

    // Nominal divide
    start_op(10'd100, 10'd7);
    complete(10'd100, 10'd7, 0, 0, 1, 9);
    check("nominal_q", out_q, 14);
    release_out(0);

    // Divide by zero
    start_op(10'd55, 10'd0);
    complete(10'd55, 10'd0, 1, 0, 0, 3);
    check("dvz_err", err_count, 1);
    release_out(0);

    // Timeout, then a late result landing in HOLD
    start_op(10'd300, 10'd3);
    complete(10'd300, 10'd3, 0, 0, 0, TIMEOUT);
    repeat (4) step();
    div_valid = 1'b1; div_q = 10'h155;
    step();
    div_valid = 1'b0;
    check("late_q", out_q, 0);
    check("late_status", out_status, 3);
    release_out(0);

    // Completion in the last timer cycle beats the timeout
    start_op(10'd90, 10'd9);
    complete(10'd90, 10'd9, 0, 0, 1, TIMEOUT - 1);
    release_out(0);

    // Backpressure with a new pair waiting upstream
    start_op(10'd200, 10'd9);
    complete(10'd200, 10'd9, 0, 0, 1, 0);
    in_a = 10'd77; in_b = 10'd5; in_valid = 1'b1;
    repeat (6) begin
      step();
      check("bp_in_ready", in_ready, 0);
      check("bp_q", out_q, exp_q);
      check("bp_no_start", div_start, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    s_start = n_start;
    step();
    in_valid = 1'b0;
    issue_check(10'd77, 10'd5);
    complete(10'd77, 10'd5, 0, 0, 1, 2);
    release_out(0);

    // Simultaneous ovf + valid, then a stray pulse in IDLE
    start_op(10'd1000, 10'd1);
    complete(10'd1000, 10'd1, 0, 1, 1, 1);
    release_out(0);
    div_valid = 1'b1; div_q = 10'h2A;
    step();
    div_valid = 1'b0;
    step();
    check("stray_valid", out_valid, 0);
    check("stray_start", div_start, 0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom_range(0, 40));
      dvz = ($urandom_range(0, 5) == 0);
      ovf = ($urandom_range(0, 5) == 0);
      vld = ($urandom_range(0, 5) != 0);
      d   = $urandom_range(0, TIMEOUT + 2);
      start_op(a, b);
      complete(a, b, dvz, ovf, vld, d);
      release_out($urandom_range(0, 3));
    end

    // Drive the error counter into saturation
    for (int i = 0; i < 260; i++) begin
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      dvz = $urandom_range(0, 1);
      start_op(a, b);
      complete(a, b, dvz, !dvz, $urandom_range(0, 1), 0);
      release_out(0);
    end
    check("saturated", err_count, 255);

    // Reset three cycles into WAIT
    start_op(10'd500, 10'd4);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    exp_err = 0;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 1);
    check("arst_start", div_start, 0);
    check("arst_div_a", div_a, 0);
    check("arst_div_b", div_b, 0);
    check("arst_q", out_q, 0);
    check("arst_status", out_status, 0);
    check("arst_err", err_count, 0);
    step();
    rst_n = 1'b1;
    div_valid = 1'b1; div_q = 10'd125;
    step();
    div_valid = 1'b0;
    step();
    check("post_rst_valid", out_valid, 0);
    check("post_rst_ready", in_ready, 1);

    // Normal service resumes after reset
    start_op(10'd999, 10'd3);
    complete(10'd999, 10'd3, 0, 0, 1, 0);
    release_out(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
